// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp sequencer: register map, control-word bits and the state encoding.
package pwm_pkg;

  localparam logic [15:0] CTRL_ADDR = 16'd0;
  localparam logic [15:0] DIV_ADDR  = 16'd2;
  localparam logic [15:0] PER_ADDR  = 16'd4;
  localparam logic [15:0] DUTY_ADDR = 16'd6;

  localparam int CTRL_EXT_CLK  = 0;
  localparam int CTRL_PWM_MODE = 1;
  localparam int CTRL_CNT_EN   = 2;
  localparam int CTRL_CONT     = 3;
  localparam int CTRL_OUT_EN   = 4;
  localparam int CTRL_IRQ_CLR  = 5;
  localparam int CTRL_DUTY_SEL = 6;
  localparam int CTRL_SOFT_RST = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_DIV,
    ST_W_PER,
    ST_W_DUTY0,
    ST_W_CTRL,
    ST_RAMP_GAP,
    ST_W_RAMP,
    ST_DONE,
    ST_W_KILL
  } seq_state_t;

endpackage

// File: rtl/pwm_ramp_sequencer_wb_write_master.sv
// Single-write Wishbone engine: latches address/data on req, holds cyc/stb until ack or timeout.
module wb_write_master #(
  parameter int DW          = 16,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [DW-1:0] adr,
  input  logic [DW-1:0] data,
  input  logic          ack,
  output logic          cyc,
  output logic          stb,
  output logic          we,
  output logic [DW-1:0] wb_adr,
  output logic [DW-1:0] wb_data,
  output logic          active,
  output logic          done,
  output logic          timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic          expire;

  assign expire  = (cnt == CW'(ACK_TIMEOUT - 1));
  assign done    = active && ack;
  // Ack in the expiry cycle still counts as a successful write.
  assign timeout = active && !ack && expire;
  assign cyc     = active;
  assign stb     = active;
  assign we      = active;

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      wb_adr  <= '0;
      wb_data <= '0;
    end else if (active) begin
      if (ack || expire) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (req) begin
      active  <= 1'b1;
      cnt     <= '0;
      wb_adr  <= adr;
      wb_data <= data;
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Programs the PWM register file over Wishbone, then ramps the duty register toward a target.
// Optional SEQ_SAFE_ABORT_EN: an abort finishes with a write that clears the output-enable bit.
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int            DW          = 16,
  parameter logic [DW-1:0] ADDR_CTRL   = DW'(CTRL_ADDR),
  parameter logic [DW-1:0] ADDR_DIV    = DW'(DIV_ADDR),
  parameter logic [DW-1:0] ADDR_PER    = DW'(PER_ADDR),
  parameter logic [DW-1:0] ADDR_DUTY   = DW'(DUTY_ADDR),
  parameter int            ACK_TIMEOUT = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [DW-1:0] i_divisor,
  input  logic [DW-1:0] i_period,
  input  logic [7:0]    i_ctrl,
  input  logic [DW-1:0] i_duty_start,
  input  logic [DW-1:0] i_duty_target,
  input  logic [DW-1:0] i_step,
  input  logic [DW-1:0] i_interval,
  input  logic          i_wb_ack,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [DW-1:0] o_wb_adr,
  output logic [DW-1:0] o_wb_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [DW-1:0] o_duty_cur
);

`ifdef SEQ_SAFE_ABORT_EN
  localparam seq_state_t ABORT_STATE = ST_W_KILL;
`else
  localparam seq_state_t ABORT_STATE = ST_IDLE;
`endif

  seq_state_t    state, state_n;
  logic [DW-1:0] div_q, per_q, start_q, target_q, step_q, interval_q;
  logic [7:0]    ctrl_q;
  logic [DW-1:0] gap_cnt, duty_cur, next_duty, wr_adr, wr_data;
  logic [DW:0]   up_sum;
  logic          abort_pend, abort_now, req;
  logic          wm_active, wm_done, wm_timeout;

  wb_write_master #(.DW(DW), .ACK_TIMEOUT(ACK_TIMEOUT)) u_wm (
    .clk(i_clk), .rst(i_rst), .req(req), .adr(wr_adr), .data(wr_data), .ack(i_wb_ack),
    .cyc(o_wb_cyc), .stb(o_wb_stb), .we(o_wb_we), .wb_adr(o_wb_adr), .wb_data(o_wb_data),
    .active(wm_active), .done(wm_done), .timeout(wm_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      div_q      <= '0;
      per_q      <= '0;
      ctrl_q     <= '0;
      start_q    <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      gap_cnt    <= '0;
      duty_cur   <= '0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && i_start) begin
        div_q      <= i_divisor;
        per_q      <= i_period;
        ctrl_q     <= i_ctrl;
        start_q    <= i_duty_start;
        target_q   <= i_duty_target;
        step_q     <= i_step;
        interval_q <= i_interval;
      end
      if (state == ST_IDLE)
        abort_pend <= 1'b0;
      else if (i_abort)
        abort_pend <= 1'b1;
      gap_cnt <= (state == ST_RAMP_GAP) ? gap_cnt + DW'(1) : '0;
      if (wm_done && state == ST_W_DUTY0)
        duty_cur <= start_q;
      else if (wm_done && state == ST_W_RAMP)
        duty_cur <= next_duty;
    end
  end

  // Upward sum is one bit wider so a step past the top of range clamps instead of wrapping.
  always_comb begin
    up_sum    = {1'b0, duty_cur} + {1'b0, step_q};
    next_duty = target_q;
    if (step_q != '0) begin
      if (duty_cur < target_q) begin
        if (up_sum < {1'b0, target_q})
          next_duty = up_sum[DW-1:0];
      end else if (duty_cur > target_q) begin
        if ((duty_cur - target_q) > step_q)
          next_duty = duty_cur - step_q;
      end
    end
  end

  always_comb begin
    wr_adr  = '0;
    wr_data = '0;
    case (state)
      ST_W_DIV:   begin wr_adr = ADDR_DIV;  wr_data = div_q;       end
      ST_W_PER:   begin wr_adr = ADDR_PER;  wr_data = per_q;       end
      ST_W_DUTY0: begin wr_adr = ADDR_DUTY; wr_data = start_q;     end
      ST_W_CTRL:  begin wr_adr = ADDR_CTRL; wr_data = DW'(ctrl_q); end
      ST_W_RAMP:  begin wr_adr = ADDR_DUTY; wr_data = next_duty;   end
      ST_W_KILL:  begin
        wr_adr  = ADDR_CTRL;
        wr_data = DW'(ctrl_q & ~(8'd1 << CTRL_OUT_EN));
      end
      default: ;
    endcase
  end

  // Write states issue req only while the engine is idle, which guarantees a gap cycle between transfers.
  always_comb begin
    state_n   = state;
    req       = 1'b0;
    abort_now = i_abort || abort_pend;
    case (state)
      ST_IDLE: if (i_start) state_n = ST_W_DIV;
      ST_W_DIV, ST_W_PER, ST_W_DUTY0, ST_W_CTRL, ST_W_RAMP, ST_W_KILL: begin
        if (!wm_active) begin
          if (abort_now && state != ST_W_KILL) state_n = ABORT_STATE;
          else req = 1'b1;
        end else if (wm_done) begin
          if (abort_now && state != ST_W_KILL) state_n = ABORT_STATE;
          else begin
            case (state)
              ST_W_DIV:   state_n = ST_W_PER;
              ST_W_PER:   state_n = ST_W_DUTY0;
              ST_W_DUTY0: state_n = ST_W_CTRL;
              ST_W_CTRL:  state_n = (start_q == target_q) ? ST_DONE : ST_RAMP_GAP;
              ST_W_RAMP:  state_n = ST_RAMP_GAP;
              default:    state_n = ST_IDLE;
            endcase
          end
        end else if (wm_timeout) begin
          state_n = ST_IDLE;
        end
      end
      ST_RAMP_GAP: begin
        if (abort_now) state_n = ABORT_STATE;
        else if (duty_cur == target_q) state_n = ST_DONE;
        else if (gap_cnt >= interval_q) state_n = ST_W_RAMP;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE);
  assign o_err      = wm_timeout;
  assign o_duty_cur = duty_cur;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with a latency-configurable Wishbone slave model.
module tb_pwm_ramp_sequencer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0, i_wb_ack = 1'b0;
  logic [15:0] i_divisor = '0, i_period = '0, i_duty_start = '0, i_duty_target = '0;
  logic [15:0] i_step = '0, i_interval = '0;
  logic [7:0]  i_ctrl = '0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we, o_busy, o_done, o_err;
  logic [15:0] o_wb_adr, o_wb_data, o_duty_cur;

  int compared = 0, mismatched = 0;
  int lat = 1, noack_adr = -1;
  int stb_run = 0, idle_run = 0, last_stb_len = 0, done_cnt = 0, err_cnt = 0;
  bit stb_prev = 0, busy_at_err = 0;
  logic [31:0] wr_q[$], exp_wr[$];
  logic [15:0] exp_duty[$];
  int idle_q[$];

  always #5 clk = ~clk;

  pwm_ramp_sequencer dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_divisor(i_divisor), .i_period(i_period), .i_ctrl(i_ctrl),
    .i_duty_start(i_duty_start), .i_duty_target(i_duty_target),
    .i_step(i_step), .i_interval(i_interval), .i_wb_ack(i_wb_ack),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_adr(o_wb_adr), .o_wb_data(o_wb_data), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_duty_cur(o_duty_cur)
  );

  // Slave model and bus monitor: acks in the lat-th strobe cycle unless the address is blocked.
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_err) begin err_cnt++; busy_at_err = o_busy; end
    if (o_wb_stb) begin
      if (!stb_prev) begin idle_q.push_back(idle_run); idle_run = 0; end
      stb_run++;
      if (!i_wb_ack && stb_run >= lat && int'(o_wb_adr) != noack_adr) begin
        i_wb_ack = 1'b1;
        wr_q.push_back({o_wb_adr, o_wb_data});
      end
    end else begin
      if (stb_prev) last_stb_len = stb_run;
      stb_run = 0;
      idle_run++;
      i_wb_ack = 1'b0;
    end
    stb_prev = o_wb_stb;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] dv, pr, input logic [7:0] ct,
                               input logic [15:0] d0, dt, st, iv, input logic ab);
    @(posedge clk); #1;
    i_divisor = dv; i_period = pr; i_ctrl = ct; i_duty_start = d0;
    i_duty_target = dt; i_step = st; i_interval = iv;
    i_start = 1'b1; i_abort = ab;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  task automatic clearLog();
    wr_q.delete(); idle_q.delete(); exp_duty.delete();
    done_cnt = 0; err_cnt = 0; busy_at_err = 0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (o_busy && n < 3000) begin @(negedge clk); n++; end
    #1;
    checkOutput(tag, 32'(o_busy), 32'd0);
  endtask

  task automatic waitStb(input string tag, input logic [15:0] adr, input logic [15:0] data,
                         input bit any_data);
    bit found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk); #1;
      if (o_wb_stb && o_wb_adr == adr && (any_data || o_wb_data == data)) found = 1;
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  task automatic checkDutyWrites(input string tag);
    logic [15:0] got[$];
    foreach (wr_q[i]) if (wr_q[i][31:16] == 16'd6) got.push_back(wr_q[i][15:0]);
    checkOutput({tag, " duty count"}, 32'(got.size()), 32'(exp_duty.size()));
    for (int i = 0; i < exp_duty.size() && i < got.size(); i++)
      checkOutput($sformatf("%s duty[%0d]", tag, i), 32'(got[i]), 32'(exp_duty[i]));
  endtask

  task automatic checkAllWrites(input string tag);
    checkOutput({tag, " write count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      checkOutput($sformatf("%s write[%0d]", tag, i), wr_q[i], exp_wr[i]);
  endtask

  initial begin
    int min_gap;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cyc", 32'(o_wb_cyc), 0);
    checkOutput("reset busy", 32'(o_busy), 0);
    checkOutput("reset adr/data", {o_wb_adr, o_wb_data}, 0);
    checkOutput("reset duty_cur", 32'(o_duty_cur), 0);
    i_rst = 1'b0;

    // Abort while idle must not start anything.
    @(posedge clk); #1; i_abort = 1'b1;
    @(posedge clk); #1; i_abort = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle abort busy", 32'(o_busy), 0);
    checkOutput("idle abort stb", 32'(o_wb_stb), 0);

    // Test 1: full up ramp with 1-cycle slave.
    $display("[TB] test 1: up ramp 0->50 step 10 interval 3");
    clearLog(); lat = 1;
    exp_wr.delete();
    exp_wr.push_back({16'd2, 16'd4});  exp_wr.push_back({16'd4, 16'd100});
    exp_wr.push_back({16'd6, 16'd0});  exp_wr.push_back({16'd0, 16'h0016});
    exp_wr.push_back({16'd6, 16'd10}); exp_wr.push_back({16'd6, 16'd20});
    exp_wr.push_back({16'd6, 16'd30}); exp_wr.push_back({16'd6, 16'd40});
    exp_wr.push_back({16'd6, 16'd50});
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd0, 16'd50, 16'd10, 16'd3, 1'b0);
    checkOutput("t1 busy rises", 32'(o_busy), 1);
    waitIdle("t1 finished");
    checkAllWrites("t1");
    min_gap = 1000;
    for (int i = 4; i < idle_q.size(); i++) if (idle_q[i] < min_gap) min_gap = idle_q[i];
    checkOutput("t1 ramp gap >= 3", 32'(min_gap >= 3), 1);
    checkOutput("t1 done pulses", 32'(done_cnt), 1);
    checkOutput("t1 err pulses", 32'(err_cnt), 0);
    checkOutput("t1 duty_cur", 32'(o_duty_cur), 50);

    // Test 2: down ramps.
    $display("[TB] test 2: down ramp 50->5");
    clearLog();
    exp_duty.push_back(16'd50); exp_duty.push_back(16'd30);
    exp_duty.push_back(16'd10); exp_duty.push_back(16'd5);
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd50, 16'd5, 16'd20, 16'd0, 1'b0);
    waitIdle("t2a finished");
    checkDutyWrites("t2a");
    checkOutput("t2a duty_cur", 32'(o_duty_cur), 5);
    clearLog();
    exp_duty.push_back(16'd50); exp_duty.push_back(16'd5);
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd50, 16'd5, 16'd0, 16'd2, 1'b0);
    waitIdle("t2b finished");
    checkDutyWrites("t2b");
    checkOutput("t2b done pulses", 32'(done_cnt), 1);

    // Test 3: top-of-range boundaries.
    $display("[TB] test 3: overflow boundaries");
    clearLog();
    exp_duty.push_back(16'hFFFF);
    applyStimulus(16'd1, 16'd10, 8'h04, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
    waitIdle("t3a finished");
    checkDutyWrites("t3a");
    checkOutput("t3a total writes", 32'(wr_q.size()), 4);
    checkOutput("t3a duty_cur", 32'(o_duty_cur), 32'hFFFF);
    checkOutput("t3a done pulses", 32'(done_cnt), 1);
    clearLog();
    exp_duty.push_back(16'hFFF0); exp_duty.push_back(16'hFFFF);
    applyStimulus(16'd1, 16'd10, 8'h04, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 1'b0);
    waitIdle("t3b finished");
    checkDutyWrites("t3b");
    checkOutput("t3b duty_cur", 32'(o_duty_cur), 32'hFFFF);

    // Test 4: slave never acks the period write.
    $display("[TB] test 4: ack timeout on period write");
    clearLog(); noack_adr = 4;
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd0, 16'd50, 16'd10, 16'd0, 1'b0);
    waitIdle("t4 finished");
    checkOutput("t4 err pulses", 32'(err_cnt), 1);
    checkOutput("t4 busy at err", 32'(busy_at_err), 1);
    checkOutput("t4 done pulses", 32'(done_cnt), 0);
    checkOutput("t4 stb length", 32'(last_stb_len), 32);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("t4 writes acked", 32'(wr_q.size()), 1);
    checkOutput("t4 stb idle", 32'(o_wb_stb), 0);
    checkOutput("t4 duty_cur kept", 32'(o_duty_cur), 32'hFFFF);
    noack_adr = -1;

    // Test 5: abort during a slow ramp write.
    $display("[TB] test 5: abort mid ramp write");
    clearLog(); lat = 5;
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd0, 16'd50, 16'd10, 16'd3, 1'b0);
    waitStb("t5 ramp write seen", 16'd6, 16'd10, 1'b0);
    i_abort = 1'b1;
    @(posedge clk); #1; i_abort = 1'b0;
    waitIdle("t5 finished");
    checkOutput("t5 done pulses", 32'(done_cnt), 0);
    checkOutput("t5 err pulses", 32'(err_cnt), 0);
    checkOutput("t5 duty_cur", 32'(o_duty_cur), 10);
`ifdef SEQ_SAFE_ABORT_EN
    checkOutput("t5 total writes", 32'(wr_q.size()), 6);
    if (wr_q.size() > 0) checkOutput("t5 kill write", wr_q[wr_q.size()-1], {16'd0, 16'h0006});
`else
    checkOutput("t5 total writes", 32'(wr_q.size()), 5);
    if (wr_q.size() > 0) checkOutput("t5 last write", wr_q[wr_q.size()-1], {16'd6, 16'd10});
`endif

    // Test 6: reset mid-strobe, then a clean restart (start and abort together).
    $display("[TB] test 6: reset mid transfer and restart");
    clearLog(); lat = 3;
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd0, 16'd50, 16'd10, 16'd0, 1'b0);
    waitStb("t6 period write seen", 16'd4, 16'd0, 1'b1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6 rst cyc/stb/we", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 0);
    checkOutput("t6 rst busy/done/err", {29'd0, o_busy, o_done, o_err}, 0);
    checkOutput("t6 rst adr/data", {o_wb_adr, o_wb_data}, 0);
    i_rst = 1'b0;
    @(negedge clk); #1;
    clearLog();
    applyStimulus(16'd4, 16'd100, 8'h16, 16'd0, 16'd50, 16'd10, 16'd0, 1'b1);
    checkOutput("t6 start beats abort", 32'(o_busy), 1);
    waitIdle("t6 finished");
    checkAllWrites("t6");
    checkOutput("t6 done pulses", 32'(done_cnt), 1);
    checkOutput("t6 duty_cur", 32'(o_duty_cur), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
